multiword_csa_sequencer: RTL
============================

Name: multiword_csa_sequencer

Overview:
- Multi-precision adder front end that feeds a single N-bit carry_select_adder instance one chunk per cycle.
- Registers a W = N*K bit operand pair and a carry-in, then walks the chunks from LSB to MSB, chaining the carry through a register.
- Presents the full W-bit sum and carry-out behind a valid/ready handshake.
- Sits directly upstream of carry_select_adder: it drives the adder's A, B and cin ports and consumes its S and cout outputs.

Parameters:
- N, 4: chunk width; the width of the instantiated carry_select_adder (its N parameter).
- K, 4: number of chunks; must be >= 1. Full operand width W = N*K is a derived localparam.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- a_in  in  W  operand A.
- b_in  in  W  operand B.
- cin_in  in  1  carry into chunk 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  W  result sum.
- cout_out  out  1  carry out of the MSB chunk.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, immediate, including mid-operation):
  - State = IDLE, idx = 0, carry register = 0, operand registers = 0.
  - sum_out = 0, cout_out = 0, out_valid = 0, busy = 0, in_ready = 1.
- States: IDLE, RUN, DONE. Encoding is free. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE:
  - On in_valid & in_ready: a_reg <= a_in, b_reg <= b_in, carry <= cin_in, idx <= 0, go to RUN.
  - Otherwise hold all state.
- RUN, every cycle:
  - Adder inputs: A = a_reg[idx*N +: N], B = b_reg[idx*N +: N], cin = carry.
  - sum_reg[idx*N +: N] <= S, carry <= cout.
  - If idx == K-1: cout_out <= cout, idx <= 0, go to DONE. Otherwise idx <= idx+1.
  - in_valid is ignored during RUN.
- DONE:
  - sum_out and cout_out are held stable.
  - On out_ready: go to IDLE. in_ready rises in the cycle after the handshake edge.
  - out_ready low: stay in DONE indefinitely; inputs are ignored.
- Latency:
  - Accept edge e0; chunk i is written at edge e0+1+i.
  - out_valid is high from edge e0+K.
  - Minimum period between accepts is K+2 cycles.
- sum_out is driven directly from sum_reg and updates chunk by chunk during RUN. It is defined only while out_valid = 1; the bench checks it only then.
- Arithmetic: {cout_out, sum_out} == a + b + cin, modulo 2^(W+1), unsigned, no saturation.
- Counter:
  - idx width = max(1, clog2(K)).
  - idx never exceeds K-1; wrap back to 0 happens on the DONE transition.
  - K = 1 gives a single RUN cycle.
- When no outstanding handshake exists, out_ready is don't-care outside DONE.

Optional Feature:
- Macro: SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf_out (1 bit), reset 0.
  - On the RUN→DONE transition: ovf_out <= (a_reg[W-1] == b_reg[W-1]) && (S[N-1] != a_reg[W-1]), i.e. two's-complement overflow of the full W-bit add.
  - ovf_out is held in DONE and defined only while out_valid = 1.
- Undefined: the ovf_out port and its logic are absent. All other behaviour is identical.

Test Plan:
- Assert rst for 2 cycles, then release -> out_valid = 0, in_ready = 1, busy = 0, sum_out = 0x0000, cout_out = 0.
- N=4, K=4: a = 0x1234, b = 0x4321, cin = 0, out_ready = 1 -> sum_out = 0x5555, cout_out = 0; out_valid high exactly 4 edges after the accept edge and for one cycle only.
- a = 0xFFFF, b = 0x0000, cin = 1 -> sum_out = 0x0000, cout_out = 1 (carry ripples through all 4 chunks).
- Backpressure: after out_valid, hold out_ready = 0 for 5 cycles with in_valid = 1 and a new operand on the inputs -> sum_out and cout_out stable, in_ready = 0, nothing accepted. Raise out_ready -> IDLE next cycle; the new operand is accepted the cycle after that.
- Assert rst asynchronously mid-clock after 2 RUN cycles -> out_valid = 0, in_ready = 1 without waiting for a clock edge. Then a = 0x8000, b = 0x8000, cin = 0 -> sum_out = 0x0000, cout_out = 1.
- With SIGNED_OVF_EN defined:
  - 0x7FFF + 0x0001 -> ovf_out = 1.
  - 0xFFFF + 0x0001 -> ovf_out = 0, cout_out = 1.
  - Also sweep all 256 (a, b) pairs with K = 1, N = 4, cin in {0, 1} -> zero mismatches against a + b + cin.

Source files
------------

// File: rtl/multiword_csa_sequencer.sv
// Multi-precision adder: walks an N*K-bit operand pair through one N-bit carry-select adder, LSB chunk first.
// Optional SIGNED_OVF_EN adds ovf_out, the two's-complement overflow flag of the full-width add.

module carry_select_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  generate
    if (N < 2) begin : g_single
      logic [N:0] full;
      assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      assign s    = full[N-1:0];
      assign cout = full[N];
    end else begin : g_split
      localparam int LO = N / 2;
      localparam int HI = N - LO;
      logic [LO:0] lo_sum;
      logic [HI:0] hi_sum0;
      logic [HI:0] hi_sum1;
      assign lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
      // Upper half precomputed for both carries; low-half carry picks one.
      assign hi_sum0 = {1'b0, a[N-1:LO]} + {1'b0, b[N-1:LO]};
      assign hi_sum1 = {1'b0, a[N-1:LO]} + {1'b0, b[N-1:LO]} + {{HI{1'b0}}, 1'b1};
      assign s    = {lo_sum[LO] ? hi_sum1[HI-1:0] : hi_sum0[HI-1:0], lo_sum[LO-1:0]};
      assign cout = lo_sum[LO] ? hi_sum1[HI] : hi_sum0[HI];
    end
  endgenerate
endmodule

// state | meaning
// IDLE  | ready for an operand pair
// RUN   | one chunk added per cycle, carry chained through a register
// DONE  | result held until out_ready
module multiword_csa_sequencer #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a_in,
  input  logic [N*K-1:0] b_in,
  input  logic           cin_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] sum_out,
  output logic           cout_out,
  output logic           busy
`ifdef SIGNED_OVF_EN
  ,
  output logic           ovf_out
`endif
);
  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg, b_reg, sum_reg;
  logic          carry, cout_reg;
  logic [N-1:0]  add_a, add_b, add_s;
  logic          add_cout;
  logic          last;

  assign last  = (idx == IDX_LAST);
  assign add_a = a_reg[idx*N +: N];
  assign add_b = b_reg[idx*N +: N];

  carry_select_adder #(.N(N)) u_csa (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            carry <= cin_in;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx*N +: N] <= add_s;
          carry               <= add_cout;
          if (last) begin
            cout_reg <= add_cout;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIGNED_OVF_EN
  logic ovf_reg;
  // The final chunk's sum MSB is the MSB of the full-width result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (add_s[N-1] != a_reg[W-1]);
    end
  end
  assign ovf_out = ovf_reg;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum_out   = sum_reg;
  assign cout_out  = cout_reg;
endmodule
